// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit.
package pc_fetch_unit_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      TRAP  = 2'd3
   } pc_state_t;

   // A redirect target is usable only when it lands on an instruction boundary.
   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_plus_4.sv
// Sequential-address incrementer: next instruction address, wrapping mod 2^XLEN.
module PC_plus_4
   import pc_fetch_unit_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_4
);

   assign pc_plus_4 = pc + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch sequencer with redirect and misalignment trap.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            jump,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] branch_target,
   input  logic            imem_ack,
   input  logic            trap_clear,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCplus4,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   output logic            pc_valid,
   output logic [XLEN-1:0] fetched_pc,
   output logic            misaligned,
   output logic [XLEN-1:0] trap_addr
);

   pc_state_t       state, state_next;
   logic [XLEN-1:0] pc_next, fetched_pc_next, trap_addr_next;
   logic            pc_valid_next, misaligned_next;
   logic            redirect;
   logic [XLEN-1:0] redirect_target;

   PC_plus_4 u_pc_plus_4 (
      .pc        (PC),
      .pc_plus_4 (PCplus4)
   );

   // Only FETCH presents a request; the address is always the current PC.
   assign imem_req  = (state == FETCH);
   assign imem_addr = PC;

   // Jump wins over branch when both fire.
   assign redirect        = jump | branch_taken;
   assign redirect_target = jump ? jump_target : branch_target;

   // Next-state and next-register selection; pc_valid is a single-cycle pulse.
   always_comb begin
      state_next      = state;
      pc_next         = PC;
      pc_valid_next   = 1'b0;
      fetched_pc_next = fetched_pc;
      misaligned_next = misaligned;
      trap_addr_next  = trap_addr;

      if (state == TRAP) begin
         if (trap_clear) begin
            pc_next         = RESET_VECTOR;
            misaligned_next = 1'b0;
            state_next      = BOOT;
         end
      end else if (redirect && !is_aligned(redirect_target)) begin
         misaligned_next = 1'b1;
         trap_addr_next  = redirect_target;
         state_next      = TRAP;
      end else if (redirect) begin
         pc_next    = redirect_target;
         state_next = FETCH;
      end else if (state == BOOT) begin
         state_next = FETCH;
      end else if (imem_req && imem_ack) begin
         pc_next         = PCplus4;
         pc_valid_next   = 1'b1;
         fetched_pc_next = PC;
         state_next      = stall ? STALL : FETCH;
      end else if (state == FETCH && stall) begin
         state_next = STALL;
      end else if (state == STALL && !stall) begin
         state_next = FETCH;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= BOOT;
         PC         <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         fetched_pc <= '0;
         misaligned <= 1'b0;
         trap_addr  <= '0;
      end else begin
         state      <= state_next;
         PC         <= pc_next;
         pc_valid   <= pc_valid_next;
         fetched_pc <= fetched_pc_next;
         misaligned <= misaligned_next;
         trap_addr  <= trap_addr_next;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random stimulus vs. a behavioural model.
module tb_pc_fetch_unit;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stall, jump, branch_taken, imem_ack, trap_clear;
   logic [31:0] jump_target, branch_target;
   logic [31:0] PC, PCplus4, imem_addr, fetched_pc, trap_addr;
   logic        imem_req, pc_valid, misaligned;

   int checks = 0;
   int errors = 0;

   // Behavioural model: "booting", "trapped" and "requesting" flags plus register values.
   logic        m_boot, m_trap, m_req, m_valid, m_mis;
   logic [31:0] m_pc, m_fpc, m_taddr;

   pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
      .clk(clk), .reset(reset), .stall(stall), .jump(jump), .branch_taken(branch_taken),
      .jump_target(jump_target), .branch_target(branch_target), .imem_ack(imem_ack),
      .trap_clear(trap_clear), .PC(PC), .PCplus4(PCplus4), .imem_req(imem_req),
      .imem_addr(imem_addr), .pc_valid(pc_valid), .fetched_pc(fetched_pc),
      .misaligned(misaligned), .trap_addr(trap_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [194:0] observed();
      return {PC, PCplus4, imem_req, imem_addr, pc_valid, fetched_pc, misaligned, trap_addr};
   endfunction

   function automatic logic [194:0] expected();
      return {m_pc, m_pc + 32'd4, m_req, m_pc, m_valid, m_fpc, m_mis, m_taddr};
   endfunction

   // Drive one cycle of inputs, advance the model by the rules, wait for the edge.
   task automatic tick(input logic r, input logic s, input logic j, input logic b,
                       input logic ack, input logic tc, input logic [31:0] jt, input logic [31:0] bt);
      logic [31:0] tgt;
      reset = r; stall = s; jump = j; branch_taken = b; imem_ack = ack; trap_clear = tc;
      jump_target = jt; branch_target = bt;
      tgt = j ? jt : bt;
      m_valid = 1'b0;
      if (r) begin
         m_boot = 1; m_trap = 0; m_req = 0; m_pc = RV; m_fpc = 0; m_mis = 0; m_taddr = 0;
      end else if (m_trap) begin
         if (tc) begin
            m_pc = RV; m_mis = 0; m_trap = 0; m_boot = 1; m_req = 0;
         end
      end else if ((j || b) && (tgt % 4 != 0)) begin
         m_mis = 1; m_taddr = tgt; m_trap = 1; m_boot = 0; m_req = 0;
      end else if (j || b) begin
         m_pc = tgt; m_req = 1; m_boot = 0;
      end else if (m_boot) begin
         m_boot = 0; m_req = 1;
      end else if (m_req && ack) begin
         m_valid = 1; m_fpc = m_pc; m_pc = m_pc + 32'd4; m_req = !s;
      end else if (m_req && s) begin
         m_req = 0;
      end else if (!m_req && !s) begin
         m_req = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 1, 1, 1, 1, 32'h40, 32'h80);
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({PC, imem_req, pc_valid, fetched_pc, misaligned, trap_addr} !== {RV, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
         errors++; $display("FAIL reset_state got pc=%h req=%b vld=%b fpc=%h mis=%b ta=%h", PC, imem_req, pc_valid, fetched_pc, misaligned, trap_addr);
      end
   endtask

   task automatic test_seq_fetch();
      tick(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b1 || PC !== 32'h0 || pc_valid !== 1'b0) begin
         errors++; $display("FAIL first_req got req=%b pc=%h vld=%b want 1 0 0", imem_req, PC, pc_valid);
      end
      tick(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (PC !== 32'h4 || pc_valid !== 1'b1 || fetched_pc !== 32'h0) begin
         errors++; $display("FAIL seq_fetch1 got pc=%h vld=%b fpc=%h want 4 1 0", PC, pc_valid, fetched_pc);
      end
      tick(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (PC !== 32'h8 || pc_valid !== 1'b1 || fetched_pc !== 32'h4 || PCplus4 !== 32'hC || imem_addr !== 32'h8) begin
         errors++; $display("FAIL seq_fetch2 got pc=%h vld=%b fpc=%h p4=%h addr=%h", PC, pc_valid, fetched_pc, PCplus4, imem_addr);
      end
   endtask

   task automatic test_wrap();
      tick(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
      checks++;
      if (PC !== 32'hFFFF_FFFC || PCplus4 !== 32'h0) begin
         errors++; $display("FAIL wrap_load got pc=%h p4=%h want fffffffc 0", PC, PCplus4);
      end
      tick(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (PC !== 32'h0 || misaligned !== 1'b0 || fetched_pc !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap got pc=%h mis=%b fpc=%h want 0 0 fffffffc", PC, misaligned, fetched_pc);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      tick(0, 0, 1, 0, 0, 0, 32'h0000_0020, 0);
      held = PC;
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 0, 0, 0, 0, 0, 0);
         checks++;
         if (imem_req !== 1'b0 || PC !== held) begin
            errors++; $display("FAIL stall_hold cyc=%0d got req=%b pc=%h want 0 %h", i, imem_req, PC, held);
         end
      end
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b1 || PC !== held) begin
         errors++; $display("FAIL stall_resume got req=%b pc=%h want 1 %h", imem_req, PC, held);
      end
      tick(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (pc_valid !== 1'b1 || fetched_pc !== held || PC !== held + 32'd4) begin
         errors++; $display("FAIL stall_fetch got vld=%b fpc=%h pc=%h", pc_valid, fetched_pc, PC);
      end
   endtask

   task automatic test_jump_priority();
      tick(0, 0, 1, 1, 1, 0, 32'h100, 32'h200);
      checks++;
      if (PC !== 32'h100 || pc_valid !== 1'b0 || imem_req !== 1'b1) begin
         errors++; $display("FAIL jump_prio got pc=%h vld=%b req=%b want 100 0 1", PC, pc_valid, imem_req);
      end
      tick(0, 0, 0, 1, 1, 0, 0, 32'h200);
      checks++;
      if (PC !== 32'h200 || pc_valid !== 1'b0) begin
         errors++; $display("FAIL branch got pc=%h vld=%b want 200 0", PC, pc_valid);
      end
   endtask

   task automatic test_misaligned_trap();
      tick(0, 0, 0, 1, 1, 0, 0, 32'h0000_0102);
      checks++;
      if (misaligned !== 1'b1 || trap_addr !== 32'h102 || PC !== 32'h200 || imem_req !== 1'b0) begin
         errors++; $display("FAIL misaligned got mis=%b ta=%h pc=%h req=%b want 1 102 200 0", misaligned, trap_addr, PC, imem_req);
      end
      tick(0, 0, 1, 1, 1, 0, 32'h300, 32'h401);
      checks++;
      if (misaligned !== 1'b1 || trap_addr !== 32'h102 || PC !== 32'h200 || pc_valid !== 1'b0) begin
         errors++; $display("FAIL trap_ignore got mis=%b ta=%h pc=%h vld=%b", misaligned, trap_addr, PC, pc_valid);
      end
      tick(0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (PC !== RV || misaligned !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL trap_clear got pc=%h mis=%b req=%b want %h 0 0", PC, misaligned, imem_req, RV);
      end
      tick(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b1 || PC !== RV) begin
         errors++; $display("FAIL boot_to_fetch got req=%b pc=%h want 1 %h", imem_req, PC, RV);
      end
   endtask

   task automatic test_reset_override();
      tick(0, 0, 1, 0, 0, 0, 32'h33, 0);
      tick(1, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if ({PC, imem_req, pc_valid, fetched_pc, misaligned, trap_addr} !== {RV, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
         errors++; $display("FAIL reset_in_trap got pc=%h req=%b mis=%b ta=%h", PC, imem_req, misaligned, trap_addr);
      end
      tick(0, 0, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 1, 0, 0, 0);
      checks++;
      if ({PC, imem_req, pc_valid, fetched_pc, misaligned, trap_addr} !== {RV, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
         errors++; $display("FAIL reset_in_stall got pc=%h req=%b vld=%b fpc=%h", PC, imem_req, pc_valid, fetched_pc);
      end
   endtask

   task automatic test_random();
      logic [31:0] jt, bt;
      for (int i = 0; i < 400; i++) begin
         jt = $urandom & 32'hFFFF_FFF0;
         bt = $urandom & 32'hFFFF_FFF0;
         if ($urandom_range(0, 3) == 0) jt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) bt[1:0] = 2'($urandom_range(1, 3));
         tick($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, jt, bt);
         checks++;
         if (observed() !== expected()) begin
            errors++; $display("FAIL random cyc=%0d got %h want %h", i, observed(), expected());
         end
      end
   endtask

   initial begin
      reset = 1; stall = 0; jump = 0; branch_taken = 0; imem_ack = 0; trap_clear = 0;
      jump_target = 0; branch_target = 0;
      m_boot = 1; m_trap = 0; m_req = 0; m_valid = 0; m_mis = 0; m_pc = RV; m_fpc = 0; m_taddr = 0;
      test_reset();
      test_seq_fetch();
      test_wrap();
      test_stall();
      test_jump_priority();
      test_misaligned_trap();
      test_reset_override();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
